// File: rtl/rvvi_retire_serializer.sv
// Serializes multi-hart, multi-slot retire groups into one RVVI sample per cycle.
// Optional statistics (drop_count, max_occupancy) are built when RVVI_SERIALIZER_STATS_EN is defined.
module rvvi_retire_serializer #(
    parameter int NHART  = 2,
    parameter int RETIRE = 2,
    parameter int ILEN   = 32,
    parameter int XLEN   = 64,
    parameter int DEPTH  = 16,
    localparam int HW    = (NHART > 1) ? $clog2(NHART) : 1,
    localparam int SW    = (RETIRE > 1) ? $clog2(RETIRE) : 1,
    localparam int OW    = $clog2(DEPTH) + 1
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic [NHART*RETIRE-1:0]       in_valid,
    input  logic [NHART*RETIRE*ILEN-1:0]  in_insn,
    input  logic [NHART*RETIRE*XLEN-1:0]  in_pc,
    input  logic [NHART*RETIRE-1:0]       in_trap,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [HW-1:0]                 out_hart,
    output logic [SW-1:0]                 out_slot,
    output logic [ILEN-1:0]               out_insn,
    output logic [XLEN-1:0]               out_pc,
    output logic                          out_trap,
    output logic [OW-1:0]                 occupancy,
    output logic                          overflow,
    input  logic                          clr_overflow,
    output logic [15:0]                   drop_count,
    output logic [OW-1:0]                 max_occupancy
);

    localparam int NSLOT = NHART * RETIRE;
    localparam int PW    = $clog2(DEPTH);

    typedef struct packed {
        logic [HW-1:0]   hart;
        logic [SW-1:0]   slot;
        logic [ILEN-1:0] insn;
        logic [XLEN-1:0] pc;
        logic            trap;
    } entry_t;

    entry_t            mem_q [DEPTH];
    entry_t            slot_ent [NSLOT];
    entry_t            head;

    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]     occ_q, occ_d;
    logic [OW-1:0]     n_in, n_acc, free_slots;
    logic [NSLOT-1:0][PW-1:0] slot_off;
    logic              accept, drop, deq;
    logic              overflow_q, overflow_d;

    // Each valid slot lands at wr_ptr + (number of valid slots below it),
    // which packs the group hart-major, slot-minor with no holes.
    always_comb begin
        n_in = '0;
        for (int i = 0; i < NSLOT; i++) begin
            slot_off[i] = PW'(n_in);
            n_in        = n_in + OW'(in_valid[i]);
        end
    end

    always_comb begin
        for (int i = 0; i < NSLOT; i++) begin
            slot_ent[i].hart = HW'(i / RETIRE);
            slot_ent[i].slot = SW'(i % RETIRE);
            slot_ent[i].insn = in_insn[i*ILEN +: ILEN];
            slot_ent[i].pc   = in_pc[i*XLEN +: XLEN];
            slot_ent[i].trap = in_trap[i];
        end
    end

    // Admission uses pre-dequeue occupancy, so a group never relies on
    // the slot freed by a same-cycle pop.
    always_comb begin
        free_slots = OW'(DEPTH) - occ_q;
        accept     = (n_in <= free_slots);
        drop       = (n_in != '0) && !accept;
        deq        = out_valid && out_ready;
        n_acc      = accept ? n_in : '0;
        occ_d      = occ_q + n_acc - OW'(deq);
        wr_ptr_d   = wr_ptr_q + PW'(n_acc);
        rd_ptr_d   = rd_ptr_q + PW'(deq);
    end

    always_comb begin
        overflow_d = overflow_q;
        if (clr_overflow) overflow_d = 1'b0;
        if (drop)         overflow_d = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            occ_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            occ_q      <= occ_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is not reset; pointers and occupancy alone define what is live.
    always_ff @(posedge clk) begin
        for (int i = 0; i < NSLOT; i++) begin
            if (accept && in_valid[i]) begin
                mem_q[wr_ptr_q + slot_off[i]] <= slot_ent[i];
            end
        end
    end

    assign head      = mem_q[rd_ptr_q];
    assign out_valid = (occ_q != '0);
    assign out_hart  = out_valid ? head.hart : '0;
    assign out_slot  = out_valid ? head.slot : '0;
    assign out_insn  = out_valid ? head.insn : '0;
    assign out_pc    = out_valid ? head.pc   : '0;
    assign out_trap  = out_valid ? head.trap : 1'b0;
    assign occupancy = occ_q;
    assign overflow  = overflow_q;

`ifdef RVVI_SERIALIZER_STATS_EN
    logic [15:0]   drop_cnt_q;
    logic [OW-1:0] max_occ_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            drop_cnt_q <= '0;
            max_occ_q  <= '0;
        end else begin
            if (drop && (drop_cnt_q != 16'hFFFF)) drop_cnt_q <= drop_cnt_q + 16'd1;
            if (occ_d > max_occ_q)                max_occ_q  <= occ_d;
        end
    end

    assign drop_count    = drop_cnt_q;
    assign max_occupancy = max_occ_q;
`else
    assign drop_count    = '0;
    assign max_occupancy = '0;
`endif

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// Scoreboard bench for rvvi_retire_serializer (NHART=2, RETIRE=2, DEPTH=8).
module tb_rvvi_retire_serializer;

`ifdef RVVI_SERIALIZER_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_n;
    logic [3:0]   in_valid, in_trap;
    logic [127:0] in_insn;
    logic [255:0] in_pc;
    logic         out_valid, out_ready;
    logic         out_hart, out_slot, out_trap;
    logic [31:0]  out_insn;
    logic [63:0]  out_pc;
    logic [3:0]   occupancy, max_occupancy;
    logic         overflow, clr_overflow;
    logic [15:0]  drop_count;

    typedef struct {
        logic        hart;
        logic        slot;
        logic [31:0] insn;
        logic [63:0] pc;
        logic        trap;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;
    int   m_occ  = 0;
    int   seq    = 0;
    bit   mon_en = 1'b0;

    rvvi_retire_serializer #(
        .NHART(2), .RETIRE(2), .ILEN(32), .XLEN(64), .DEPTH(8)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .in_valid(in_valid), .in_insn(in_insn), .in_pc(in_pc), .in_trap(in_trap),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_hart(out_hart), .out_slot(out_slot), .out_insn(out_insn),
        .out_pc(out_pc), .out_trap(out_trap),
        .occupancy(occupancy), .overflow(overflow), .clr_overflow(clr_overflow),
        .drop_count(drop_count), .max_occupancy(max_occupancy)
    );

    always #5 clk = ~clk;

    // Dequeue happens at the next posedge whenever valid && ready here.
    always @(negedge clk) begin
        if (mon_en && reset_n && out_valid && out_ready) begin
            checks++;
            if (sbq.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected got h%0d s%0d pc=%h expected no output", out_hart, out_slot, out_pc);
            end else begin
                mon_e = sbq.pop_front();
                if ({out_hart, out_slot, out_insn, out_pc, out_trap} !==
                    {mon_e.hart, mon_e.slot, mon_e.insn, mon_e.pc, mon_e.trap}) begin
                    errors++;
                    $display("FAIL sb_entry got h%0d s%0d insn=%h pc=%h t%0d expected h%0d s%0d insn=%h pc=%h t%0d",
                             out_hart, out_slot, out_insn, out_pc, out_trap,
                             mon_e.hart, mon_e.slot, mon_e.insn, mon_e.pc, mon_e.trap);
                end
            end
        end
    end

    // Drive one cycle of retire traffic; push accepted entries to the scoreboard.
    task automatic step(input logic [3:0] v, input logic [63:0] pcb);
        int   n;
        bit   acc, deq_m;
        exp_t e;
        n     = $countones(v);
        deq_m = (m_occ != 0) && out_ready;
        acc   = (n <= 8 - m_occ);
        for (int i = 0; i < 4; i++) begin
            in_insn[i*32 +: 32] = $urandom;
            in_pc[i*64 +: 64]   = {$urandom, $urandom};
            in_trap[i]          = 1'($urandom_range(0, 1));
            if (v[i]) begin
                seq++;
                e.hart = 1'(i / 2);
                e.slot = 1'(i % 2);
                e.insn = 32'hA5A5_0000 + 32'(seq);
                e.pc   = pcb + 64'(4 * i);
                e.trap = 1'(seq % 2);
                in_insn[i*32 +: 32] = e.insn;
                in_pc[i*64 +: 64]   = e.pc;
                in_trap[i]          = e.trap;
                if (acc) sbq.push_back(e);
            end
        end
        in_valid = v;
        m_occ    = m_occ + (acc ? n : 0) - (deq_m ? 1 : 0);
        @(posedge clk);
        #1;
        in_valid     = 4'b0;
        clr_overflow = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; in_valid = '0; in_trap = '0; in_insn = '0; in_pc = '0;
        out_ready = 1'b0; clr_overflow = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0d expected 0", out_valid); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL rst_occ got %0d expected 0", occupancy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf got %0d expected 0", overflow); end
        checks++; if (drop_count !== 16'd0) begin errors++; $display("FAIL rst_drop got %0d expected 0", drop_count); end
        checks++; if (max_occupancy !== 4'd0) begin errors++; $display("FAIL rst_max got %0d expected 0", max_occupancy); end
        checks++; if ({out_hart, out_slot, out_trap, out_insn, out_pc} !== 99'd0) begin
            errors++; $display("FAIL rst_outs got insn=%h pc=%h expected 0", out_insn, out_pc); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;
    endtask

    task automatic test_order();
        out_ready = 1'b1;
        step(4'b1011, 64'h100);
        checks++; if ({out_valid, out_hart, out_slot} !== 3'b100) begin
            errors++; $display("FAIL ord_first got v%0d h%0d s%0d expected v1 h0 s0", out_valid, out_hart, out_slot); end
        checks++; if (occupancy !== 4'd3) begin errors++; $display("FAIL ord_occ got %0d expected 3", occupancy); end
        step(4'b0, 64'h0);
        checks++; if ({out_hart, out_slot} !== 2'b01) begin
            errors++; $display("FAIL ord_second got h%0d s%0d expected h0 s1", out_hart, out_slot); end
        step(4'b0, 64'h0);
        checks++; if ({out_hart, out_slot} !== 2'b11) begin
            errors++; $display("FAIL ord_third got h%0d s%0d expected h1 s1", out_hart, out_slot); end
        step(4'b0, 64'h0);
        checks++; if (occupancy !== 4'd0 || sbq.size() != 0) begin
            errors++; $display("FAIL ord_drain got occ=%0d left=%0d expected 0 0", occupancy, sbq.size()); end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b0;
        step(4'b1111, 64'h200);
        step(4'b1111, 64'h300);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL bp_full got %0d expected 8", occupancy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_noovf got %0d expected 0", overflow); end
        step(4'b0001, 64'h400);
        checks++; if (occupancy !== 4'd8) begin errors++; $display("FAIL bp_drop_occ got %0d expected 8", occupancy); end
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_ovf got %0d expected 1", overflow); end
        checks++; if (drop_count !== (STATS ? 16'd1 : 16'd0)) begin
            errors++; $display("FAIL bp_dropcnt got %0d expected %0d", drop_count, STATS ? 1 : 0); end
        checks++; if (max_occupancy !== (STATS ? 4'd8 : 4'd0)) begin
            errors++; $display("FAIL bp_max got %0d expected %0d", max_occupancy, STATS ? 8 : 0); end
    endtask

    task automatic test_clear_race();
        clr_overflow = 1'b1;
        step(4'b0001, 64'h500);
        checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL race_ovf got %0d expected 1", overflow); end
        checks++; if (drop_count !== (STATS ? 16'd2 : 16'd0)) begin
            errors++; $display("FAIL race_dropcnt got %0d expected %0d", drop_count, STATS ? 2 : 0); end
        clr_overflow = 1'b1;
        step(4'b0, 64'h0);
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf got %0d expected 0", overflow); end
        out_ready = 1'b1;
        repeat (8) step(4'b0, 64'h0);
        checks++; if (occupancy !== 4'd0 || sbq.size() != 0) begin
            errors++; $display("FAIL bp_drain got occ=%0d left=%0d expected 0 0", occupancy, sbq.size()); end
    endtask

    task automatic test_simultaneous();
        out_ready = 1'b0;
        step(4'b1111, 64'h600);
        step(4'b0001, 64'h700);
        checks++; if (occupancy !== 4'd5) begin errors++; $display("FAIL sim_pre got %0d expected 5", occupancy); end
        out_ready = 1'b1;
        step(4'b0111, 64'h800);
        checks++; if (occupancy !== 4'd7) begin errors++; $display("FAIL sim_occ got %0d expected 7", occupancy); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_ovf got %0d expected 0", overflow); end
        repeat (7) step(4'b0, 64'h0);
        checks++; if (occupancy !== 4'd0 || sbq.size() != 0) begin
            errors++; $display("FAIL sim_drain got occ=%0d left=%0d expected 0 0", occupancy, sbq.size()); end
    endtask

    task automatic test_wrap();
        out_ready = 1'b1;
        for (int k = 0; k < 20; k++) step(4'b0001, 64'h1000 + 64'(4 * k));
        step(4'b0, 64'h0);
        checks++; if (occupancy !== 4'd0 || sbq.size() != 0) begin
            errors++; $display("FAIL wrap_drain got occ=%0d left=%0d expected 0 0", occupancy, sbq.size()); end
        checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL wrap_ovf got %0d expected 0", overflow); end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b0;
        step(4'b1111, 64'h900);
        step(4'b0011, 64'hA00);
        checks++; if (occupancy !== 4'd6) begin errors++; $display("FAIL rm_pre got %0d expected 6", occupancy); end
        #2 reset_n = 1'b0;
        sbq.delete();
        m_occ = 0;
        #1;
        checks++; if (out_valid !== 1'b0 || occupancy !== 4'd0) begin
            errors++; $display("FAIL rm_async got v%0d occ=%0d expected v0 occ=0", out_valid, occupancy); end
        checks++; if (out_pc !== 64'd0) begin errors++; $display("FAIL rm_pc got %h expected 0", out_pc); end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        step(4'b0001, 64'hB00);
        checks++; if (out_valid !== 1'b1 || out_pc !== 64'hB00) begin
            errors++; $display("FAIL rm_first got v%0d pc=%h expected v1 pc=b00", out_valid, out_pc); end
        checks++; if (max_occupancy !== (STATS ? 4'd1 : 4'd0)) begin
            errors++; $display("FAIL rm_max got %0d expected %0d", max_occupancy, STATS ? 1 : 0); end
        step(4'b0, 64'h0);
        checks++; if (occupancy !== 4'd0 || sbq.size() != 0) begin
            errors++; $display("FAIL rm_drain got occ=%0d left=%0d expected 0 0", occupancy, sbq.size()); end
    endtask

    initial begin
        test_reset();
        test_order();
        test_backpressure();
        test_clear_race();
        test_simultaneous();
        test_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
